// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the UART core pins.
// The arbiter uses the slave modport; producers and the UART side use master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_wr_en;
  logic                      tx_busy;
  logic [IDW-1:0]            grant_id;
  logic                      idle;
  logic                      tx_err;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_wr_en, grant_id, idle, tx_err
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_wr_en, grant_id, idle, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a single UART transmitter with busy tracking and timeout.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index fixed priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int BUSY_TMO = 16
) (
  input  logic              clk_50m,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state;
  logic [IDW-1:0] win;
  logic           found;
  logic [7:0]     tmo_cnt;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win   = IDW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        win   = idx[IDW-1:0];
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found)
      bus.req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr          <= IDW'(NUM_REQ - 1);
`endif
      bus.tx_data  <= '0;
      bus.tx_wr_en <= 1'b0;
      bus.grant_id <= '0;
      bus.tx_err   <= 1'b0;
      bus.idle     <= 1'b1;
      tmo_cnt      <= '0;
    end else begin
      bus.tx_wr_en <= 1'b0;
      bus.tx_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.tx_data  <= bus.req_data[win*DATA_W +: DATA_W];
            bus.grant_id <= win;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr          <= win;
`endif
            bus.tx_wr_en <= 1'b1;
            bus.idle     <= 1'b0;
            state        <= STROBE;
          end
        end
        STROBE: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Leaving on the edge where the count reaches BUSY_TMO-1 puts tx_err
          // exactly BUSY_TMO cycles after the strobe.
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == 8'(BUSY_TMO - 2)) begin
            tmo_cnt    <= tmo_cnt + 8'd1;
            bus.tx_err <= 1'b1;
            bus.idle   <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            bus.idle <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected grants,
// a monitor pops and compares on every tx_wr_en strobe.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int BUSY_TMO = 16;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_en = 1'b1;
  int   busy_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic prev_wr = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TMO(BUSY_TMO)) dut (
    .clk_50m (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // UART model: busy rises the cycle after a strobe and stays high for 10 cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        bus.tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        bus.tx_busy = 1'b0;
      end
      if (model_en && bus.tx_wr_en && busy_cnt == 0 && !rst)
        busy_cnt = 10;
    end
  end

  // Monitor: every strobe must match the head of the scoreboard and last one cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_wr_en === 1'b1) begin
        check("strobe_one_cycle", {31'd0, prev_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual grant=%0d data=%0h required none",
                   bus.grant_id, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_grant_id", 32'(bus.grant_id), 32'(e.id));
          check("sb_tx_data", 32'(bus.tx_data), 32'(e.data));
        end
      end
      prev_wr = bus.tx_wr_en;
    end
  end

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Returns at the negedge of the accept cycle.
  task automatic wait_accept(input logic [3:0] mask, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((bus.req_ready & mask) != 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s actual=no_accept required=accept", name);
  endtask

  task automatic wait_strobe(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_wr_en === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s actual=no_strobe required=strobe", name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.idle === 1'b1 && bus.tx_busy === 1'b0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s actual=busy required=idle", name);
  endtask

  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_idle", 32'(bus.idle), 32'd1);
    check("rst_wr_en", 32'(bus.tx_wr_en), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_tx_err", 32'(bus.tx_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester
    @(posedge clk);
    #1;
    bus.req_data  = 32'h0000_0041;
    bus.req_valid = 4'b0001;
    push(0, 8'h41);
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    check("single_wr_en", 32'(bus.tx_wr_en), 32'd1);
    check("single_idle_low", 32'(bus.idle), 32'd0);
    wait_idle("single_idle");

    // Arbitration order with 1011 held for four transfers
    do_reset();
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
`ifdef UART_ARB_FIXED_PRIO_EN
    push(0, 8'hA0); push(0, 8'hA0); push(0, 8'hA0); push(0, 8'hA0);
`else
    push(0, 8'hA0); push(1, 8'hA1); push(3, 8'hA3); push(0, 8'hA0);
`endif
    bus.req_valid = 4'b1011;
    for (int t = 0; t < 4; t++) wait_accept(4'b1011, "rr_accept");
    @(posedge clk);
`ifdef UART_ARB_FIXED_PRIO_EN
    #1 bus.req_valid = 4'b1010;
    push(1, 8'hA1);
    wait_accept(4'b1010, "fp_drop0_accept");
    @(posedge clk);
`endif
    #1 bus.req_valid = '0;
    wait_idle("rr_idle");

    // Busy timeout
    do_reset();
    model_en = 1'b0;
    bus.req_data  = {8'h00, 8'h5A, 8'h11, 8'h00};
    bus.req_valid = 4'b0100;
    push(2, 8'h5A);
    wait_accept(4'b0100, "tmo_accept");
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_strobe("tmo_strobe");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.tx_err === 1'b1) break;
    end
    check("tmo_latency", 32'(n), 32'(BUSY_TMO));
    check("tmo_idle", 32'(bus.idle), 32'd1);
    check("tmo_ready_zero", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("tmo_err_pulse", 32'(bus.tx_err), 32'd0);
    model_en = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 4'b0010;
    push(1, 8'h11);
    wait_accept(4'b0010, "tmo_next_accept");
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle("tmo_next_idle");

    // Withdraw while busy
    @(posedge clk);
    #1;
    bus.req_data  = {8'h00, 8'hCC, 8'h00, 8'h77};
    bus.req_valid = 4'b0001;
    push(0, 8'h77);
    wait_accept(4'b0001, "wd_accept");
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_strobe("wd_strobe");
    repeat (3) @(posedge clk);
    #1 bus.req_valid = 4'b0100;
    @(negedge clk);
    check("wd_ready_zero", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle("wd_idle");
    repeat (3) @(negedge clk);
    check("wd_grant_kept", 32'(bus.grant_id), 32'd0);
    check("wd_data_kept", 32'(bus.tx_data), 32'h77);

    // Reset during WAIT_DONE
    @(posedge clk);
    #1;
    bus.req_data  = {8'h00, 8'h00, 8'h22, 8'h00};
    bus.req_valid = 4'b0010;
    push(1, 8'h22);
    wait_accept(4'b0010, "rm_accept");
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_strobe("rm_strobe");
    repeat (3) @(negedge clk);
    check("rm_busy_high", 32'(bus.tx_busy), 32'd1);
    check("rm_not_idle", 32'(bus.idle), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rm_idle", 32'(bus.idle), 32'd1);
    check("rm_tx_data", 32'(bus.tx_data), 32'd0);
    check("rm_grant_id", 32'(bus.grant_id), 32'd0);
    check("rm_wr_en", 32'(bus.tx_wr_en), 32'd0);
    check("rm_tx_err", 32'(bus.tx_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.req_data  = {8'h33, 8'h00, 8'h00, 8'h44};
    bus.req_valid = 4'b1001;
    push(0, 8'h44);
    wait_accept(4'b1001, "rm_next_accept");
    check("rm_next_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_idle("rm_next_idle");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
